// File: rtl/uart_tx_engine.sv
// uart_tx_engine
//   UART transmitter with an integrated transmit FIFO. It runs on SysClk and
//   uses a programmable baud divisor. Parity (none/even/odd), one or two stop
//   bits and CTS flow control are selected at runtime.
//
// Ports
//   SysClk        system clock, rising edge
//   Rst           asynchronous, active-high reset
//   Tx_Data       word to enqueue
//   Tx_Push       enqueue Tx_Data this cycle
//   Baud_Div      SysClk cycles per bit minus 1
//   Parity_Mode   00 none, 01 even, 10 odd, 11 none
//   Two_Stop      1 = two stop bits
//   CTS           clear-to-send, sampled only between frames
//   Tx            serial output, idle high, LSB first (registered)
//   Tx_Busy       frame in progress
//   FIFO_Empty    FIFO holds no entries
//   FIFO_Full     FIFO holds FIFO_DEPTH entries
//   FIFO_Overflow one-cycle pulse after a dropped push
//   FIFO_Count    current FIFO occupancy
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | line high; pop the head and latch frame config when CTS allows
// S_START  | start bit (low) for one bit time
// S_DATA   | DATA_BITS data bits, LSB first
// S_PARITY | parity bit, only when parity is enabled
// S_STOP   | one or two stop bits (high)

module uart_tx_engine #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                               SysClk,
    input  logic                               Rst,
    input  logic [DATA_BITS-1:0]               Tx_Data,
    input  logic                               Tx_Push,
    input  logic [DIV_WIDTH-1:0]               Baud_Div,
    input  logic [1:0]                         Parity_Mode,
    input  logic                               Two_Stop,
    input  logic                               CTS,
    output logic                               Tx,
    output logic                               Tx_Busy,
    output logic                               FIFO_Empty,
    output logic                               FIFO_Full,
    output logic                               FIFO_Overflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    FIFO_Count
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // ---------------------------------------------------------------- FIFO
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count_q;
    logic [CNT_W-1:0]     count_d;
    logic [DATA_BITS-1:0] head;
    logic                 pop;
    logic                 push_ok;

    // A push into a full FIFO is accepted when the FSM pops in the same cycle.
    assign push_ok = Tx_Push && (!FIFO_Full || pop);
    assign head    = mem[rd_ptr];

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge SysClk or posedge Rst) begin
        if (Rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count_q       <= '0;
            FIFO_Empty    <= 1'b1;
            FIFO_Full     <= 1'b0;
            FIFO_Overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count_q       <= count_d;
            FIFO_Empty    <= (count_d == '0);
            FIFO_Full     <= (count_d == CNT_FULL);
            FIFO_Overflow <= Tx_Push && FIFO_Full && !pop;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge SysClk) begin
        if (push_ok) begin
            mem[wr_ptr] <= Tx_Data;
        end
    end

    assign FIFO_Count = count_q;

    // ----------------------------------------------------------------- FSM
    state_t               state_q,    state_d;
    logic [DATA_BITS-1:0] shift_q,    shift_d;
    logic [DIV_WIDTH-1:0] timer_q,    timer_d;
    logic [DIV_WIDTH-1:0] div_q,      div_d;
    logic [IDX_W-1:0]     bit_idx_q,  bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic                 par_en_q,   par_en_d;
    logic                 par_bit_q,  par_bit_d;
    logic                 two_stop_q, two_stop_d;
    logic                 tx_q,       tx_d;
    logic                 bit_done;

    assign bit_done = (timer_q == '0);

    always_ff @(posedge SysClk or posedge Rst) begin
        if (Rst) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            timer_q    <= '0;
            div_q      <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            two_stop_q <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            timer_q    <= timer_d;
            div_q      <= div_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            two_stop_q <= two_stop_d;
            tx_q       <= tx_d;
        end
    end

    // tx_d is the line level for the next cycle, so Tx comes straight from a flop.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        timer_d    = timer_q;
        div_d      = div_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        two_stop_d = two_stop_q;
        tx_d       = tx_q;
        pop        = 1'b0;

        if (state_q != S_IDLE && !bit_done) begin
            timer_d = timer_q - DIV_WIDTH'(1);
        end

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (!FIFO_Empty && CTS) begin
                    pop        = 1'b1;
                    shift_d    = head;
                    div_d      = Baud_Div;
                    timer_d    = Baud_Div;
                    par_en_d   = (Parity_Mode == 2'b01) || (Parity_Mode == 2'b10);
                    // Parity is fixed at pop time so the frame is independent of later config.
                    par_bit_d  = (^head) ^ (Parity_Mode == 2'b10);
                    two_stop_d = Two_Stop;
                    tx_d       = 1'b0;
                    state_d    = S_START;
                end
            end
            S_START: begin
                if (bit_done) begin
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_idx_d = '0;
                    timer_d   = div_q;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    timer_d = div_q;
                    if (bit_idx_q == IDX_LAST) begin
                        if (par_en_q) begin
                            tx_d    = par_bit_q;
                            state_d = S_PARITY;
                        end else begin
                            tx_d       = 1'b1;
                            stop_idx_d = 1'b0;
                            state_d    = S_STOP;
                        end
                    end else begin
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (bit_done) begin
                    tx_d       = 1'b1;
                    timer_d    = div_q;
                    stop_idx_d = 1'b0;
                    state_d    = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_done) begin
                    tx_d = 1'b1;
                    if (two_stop_q && !stop_idx_q) begin
                        stop_idx_d = 1'b1;
                        timer_d    = div_q;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    assign Tx      = tx_q;
    assign Tx_Busy = (state_q != S_IDLE);

endmodule

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
Parametrised next-generation UART transmitter with an integrated transmit FIFO.
- Runs directly on SysClk, using an internal runtime-programmable baud divider instead of a separate generated bit clock.
- Supports runtime-selectable parity (none/even/odd), 1 or 2 stop bits, and CTS flow control.
- Sits between the host push interface and the serial Tx pin, as the successor to the fixed-format transmitter path in UARTsv.

Parameters:
DATA_BITS, 8, data bits per frame (5..9).
FIFO_DEPTH, 16, TX FIFO entries; power of two, >= 2.
DIV_WIDTH, 16, width of the baud divisor.

Ports:
SysClk  input  1  system clock; all logic rising-edge.
Rst  input  1  reset, asynchronous, active-high.
Tx_Data  input  DATA_BITS  byte to enqueue.
Tx_Push  input  1  enqueue Tx_Data this cycle.
Baud_Div  input  DIV_WIDTH  SysClk cycles per bit minus 1.
Parity_Mode  input  2  00 none, 01 even, 10 odd, 11 treated as none.
Two_Stop  input  1  1 = two stop bits, 0 = one stop bit.
CTS  input  1  clear-to-send, active-high.
Tx  output  1  serial output, idle high, LSB first.
Tx_Busy  output  1  frame in progress.
FIFO_Empty  output  1  FIFO holds 0 entries.
FIFO_Full  output  1  FIFO holds FIFO_DEPTH entries.
FIFO_Overflow  output  1  one-cycle pulse when a push is dropped.
FIFO_Count  output  $clog2(FIFO_DEPTH+1)  current occupancy.

Behaviour:
- Reset (async, any time including mid-frame):
  - Tx=1, Tx_Busy=0, FIFO_Empty=1, FIFO_Full=0, FIFO_Overflow=0, FIFO_Count=0.
  - Pointers cleared, FIFO contents discarded, FSM forced to IDLE.
- FIFO:
  - Circular buffer with read/write pointers; pointers wrap modulo FIFO_DEPTH.
  - Push when not full: write at write pointer; count +1 visible next cycle.
  - Push when full and no pop that cycle: data dropped, count unchanged, FIFO_Overflow=1 for the next cycle only.
  - Simultaneous push and pop: both occur, count unchanged. This holds when full (no overflow).
  - Empty/Full/Count are registered and derived from the count register.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: Tx=1, Tx_Busy=0.
    - If FIFO_Empty=0 and CTS=1: pop head into the shift register.
    - In the same cycle, latch Baud_Div, Parity_Mode and Two_Stop into frame registers, then go to START.
    - Config changes mid-frame do not affect the current frame.
  - START: Tx=0 for (div+1) cycles, then DATA.
  - DATA: shift LSB first, one bit per (div+1) cycles, DATA_BITS bits.
    - Afterwards go to PARITY if parity is enabled, else STOP.
  - PARITY: even → XOR of data bits; odd → inverted XOR. Lasts one bit time.
  - STOP: Tx=1 for 1 or 2 bit times, then IDLE.
  - Tx_Busy=1 in every state except IDLE.
- Bit timing:
  - Down-counter loaded with the latched div at each bit start; the bit ends when the counter reaches 0.
  - Baud_Div=0 gives 1 cycle per bit.
- Frame length is 1 + DATA_BITS + (parity?1:0) + (Two_Stop?2:1) bits.
- Latency: push in cycle t → FIFO_Empty falls at t+1 → IDLE pop at t+1 → Tx falls at t+2.
  - Back-to-back frames: the next START begins the cycle after IDLE is re-entered, i.e. 1 idle-high cycle between frames.
- Tx is driven from a register; no combinational path from inputs to Tx.
- CTS:
  - Sampled only in IDLE.
  - Deassertion mid-frame lets the current frame complete; no new frame starts until CTS=1.

Test Plan:
- DATA_BITS=8, Baud_Div=3, parity none, Two_Stop=0, push 0x55:
  - Tx falls 2 cycles after push.
  - Bits sequence is 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles, 40 cycles total.
  - Tx_Busy high exactly 40 cycles.
- Parity/stop-bit framing:
  - Parity_Mode=01, push 0x03 → parity bit 0.
  - Parity_Mode=10 → parity bit 1.
  - Two_Stop=1 → 12 bits = 48 cycles at Baud_Div=3.
- Overflow with CTS=0:
  - Push 17 bytes 0x00..0x10.
  - FIFO_Full=1 after the 16th; 17th push gives a single-cycle FIFO_Overflow, FIFO_Count stays 16.
  - Raise CTS → 0x00..0x0F transmitted in order, 1 idle cycle between frames, FIFO_Empty=1 after the 16th pop.
- Full plus simultaneous push/pop:
  - With FIFO full and CTS=1, push in the same cycle as the IDLE pop.
  - No overflow, count stays 16, the pushed byte is transmitted last.
- CTS dropped mid-DATA of frame A with frame B queued:
  - Frame A completes intact, Tx stays 1, B remains in FIFO.
  - Raising CTS starts B 1 cycle later.
- Rst asserted mid-DATA:
  - Tx=1, Tx_Busy=0, FIFO_Count=0 immediately, without waiting for a SysClk edge.
  - After release, a new push transmits normally.
